if_fetch_unit: RTL

- Parametrised instruction-fetch front end for the pipelined core.
- Holds the PC and issues pipelined fetch requests to the instruction memory port over a valid/ready handshake.
- Accepts in-order responses of variable latency into a DEPTH-entry fetch queue, then presents (pc, inst) pairs to decode over a valid/ready handshake.
- On a branch/exception redirect, flushes the queue and drops stale in-flight responses.

---
 rtl/if_fetch_unit.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/if_fetch_unit.sv
// if_fetch_unit
//   Instruction-fetch front end. Holds the PC, issues pipelined fetch requests
//   over a valid/ready handshake and collects in-order, variable-latency
//   responses into a DEPTH-entry fetch queue. The queue presents (pc, inst)
//   pairs to decode over a second valid/ready handshake. A redirect flushes
//   the queue, restarts fetch at the new PC and drops stale in-flight
//   responses.
//
// Ports
//   clk, rst            clock, synchronous active-high reset
//   redirect_valid_i    flush and redirect fetch this cycle
//   redirect_pc_i       redirect target (low instruction-offset bits ignored)
//   req_valid_o         fetch request valid
//   req_ready_i         memory accepts request
//   req_addr_o          fetch address
//   resp_valid_i        one in-order instruction returned
//   resp_data_i         returned instruction
//   out_valid_o         decode-side entry valid
//   out_ready_i         decode accepts entry
//   out_pc_o, out_inst_o  presented entry
//   resp_err_o          sticky: response arrived with nothing outstanding
module if_fetch_unit #(
  parameter int          ADDR_W   = 64,
  parameter int          INST_W   = 32,
  parameter int          DEPTH    = 4,
  parameter logic [63:0] PC_START = 64'h0000_0000_8000_0000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              redirect_valid_i,
  input  logic [ADDR_W-1:0] redirect_pc_i,
  output logic              req_valid_o,
  input  logic              req_ready_i,
  output logic [ADDR_W-1:0] req_addr_o,
  input  logic              resp_valid_i,
  input  logic [INST_W-1:0] resp_data_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [ADDR_W-1:0] out_pc_o,
  output logic [INST_W-1:0] out_inst_o,
  output logic              resp_err_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int INC   = INST_W / 8;
  localparam logic [ADDR_W-1:0] PC_RST   = PC_START[ADDR_W-1:0];
  localparam logic [ADDR_W-1:0] OFF_MASK = ADDR_W'(INC - 1);

  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [PTR_W-1:0]  head_q, head_d, alloc_q, alloc_d, fill_q, fill_d;
  // count_q: allocated entries; pend_q: allocated but not yet filled;
  // discard_q: responses still owed to requests from a flushed path.
  logic [CNT_W-1:0]  count_q, count_d, pend_q, pend_d, discard_q, discard_d;
  logic [DEPTH-1:0]  filled_q, filled_d;
  logic              err_q, err_d;
  logic              init_q;

  logic [ADDR_W-1:0] pc_mem_q   [DEPTH];
  logic [INST_W-1:0] inst_mem_q [DEPTH];

  logic req_fire, pop, resp_drop, resp_fill, resp_spur;

  // init_q holds both handshakes low for the first cycle after reset.
  assign req_valid_o = !rst && !init_q && !redirect_valid_i &&
                       (count_q < CNT_W'(DEPTH)) && (discard_q == '0);
  assign req_addr_o  = pc_q;
  assign req_fire    = req_valid_o && req_ready_i;

  assign out_valid_o = !rst && !init_q && filled_q[head_q] &&
                       (count_q != '0) && !redirect_valid_i;
  assign out_pc_o    = pc_mem_q[head_q];
  assign out_inst_o  = inst_mem_q[head_q];
  assign pop         = out_valid_o && out_ready_i;

  assign resp_drop   = resp_valid_i && (discard_q != '0);
  assign resp_fill   = resp_valid_i && (discard_q == '0) && (pend_q != '0);
  assign resp_spur   = resp_valid_i && (discard_q == '0) && (pend_q == '0);

  assign resp_err_o  = err_q;

  always_comb begin
    pc_d      = pc_q;
    head_d    = head_q;
    alloc_d   = alloc_q;
    fill_d    = fill_q;
    count_d   = count_q;
    pend_d    = pend_q;
    discard_d = discard_q;
    filled_d  = filled_q;
    err_d     = err_q;
    if (redirect_valid_i) begin
      pc_d     = redirect_pc_i & ~OFF_MASK;
      head_d   = '0;
      alloc_d  = '0;
      fill_d   = '0;
      count_d  = '0;
      pend_d   = '0;
      filled_d = '0;
      // Everything still owed (old discards plus unfilled entries) must be
      // dropped; a response arriving now settles one of them.
      if (resp_spur) begin
        err_d     = 1'b1;
        discard_d = '0;
      end else begin
        discard_d = discard_q + pend_q - CNT_W'(resp_valid_i);
      end
    end else begin
      if (req_fire) begin
        filled_d[alloc_q] = 1'b0;
        alloc_d           = alloc_q + PTR_W'(1);
        pc_d              = pc_q + ADDR_W'(INC);
      end
      if (resp_drop) discard_d = discard_q - CNT_W'(1);
      if (resp_fill) begin
        filled_d[fill_q] = 1'b1;
        fill_d           = fill_q + PTR_W'(1);
      end
      if (resp_spur) err_d = 1'b1;
      if (pop) head_d = head_q + PTR_W'(1);
      count_d = count_q + CNT_W'(req_fire) - CNT_W'(pop);
      pend_d  = pend_q + CNT_W'(req_fire) - CNT_W'(resp_fill);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q      <= PC_RST;
      head_q    <= '0;
      alloc_q   <= '0;
      fill_q    <= '0;
      count_q   <= '0;
      pend_q    <= '0;
      discard_q <= '0;
      filled_q  <= '0;
      err_q     <= 1'b0;
      init_q    <= 1'b1;
    end else begin
      pc_q      <= pc_d;
      head_q    <= head_d;
      alloc_q   <= alloc_d;
      fill_q    <= fill_d;
      count_q   <= count_d;
      pend_q    <= pend_d;
      discard_q <= discard_d;
      filled_q  <= filled_d;
      err_q     <= err_d;
      init_q    <= 1'b0;
    end
  end

  // Payload storage needs no reset; the filled bits and count qualify it.
  always_ff @(posedge clk) begin
    if (!rst && !redirect_valid_i) begin
      if (req_fire)  pc_mem_q[alloc_q]  <= pc_q;
      if (resp_fill) inst_mem_q[fill_q] <= resp_data_i;
    end
  end

endmodule
